// File: rtl/hd44780_pkg.sv
// Shared HD44780 instruction encodings, DDRAM geometry and address-counter helpers
// used by the responder and its DDRAM.
package hd44780_pkg;

  localparam int unsigned LINE_LEN    = 40;
  localparam logic [6:0]  LINE2_BASE  = 7'h40;
  localparam int unsigned DDRAM_DEPTH = 2 * LINE_LEN;
  localparam logic [7:0]  BLANK       = 8'h20;

  // Instruction prefixes; the highest set bit selects the instruction.
  localparam logic [7:0] SDL  = 8'h80;
  localparam logic [7:0] SCGA = 8'h40;
  localparam logic [7:0] FS   = 8'h20;
  localparam logic [7:0] CD   = 8'h10;
  localparam logic [7:0] DC   = 8'h08;
  localparam logic [7:0] EM   = 8'h04;
  localparam logic [7:0] HOME = 8'h02;
  localparam logic [7:0] CLR  = 8'h01;

  localparam int unsigned FS_DL = 4;
  localparam int unsigned FS_N  = 3;
  localparam int unsigned CD_SC = 3;
  localparam int unsigned CD_RL = 2;
  localparam int unsigned DC_D  = 2;
  localparam int unsigned DC_C  = 1;
  localparam int unsigned DC_B  = 0;
  localparam int unsigned EM_ID = 1;
  localparam int unsigned EM_S  = 0;

  localparam logic [6:0] AC_L1_LAST = 7'(LINE_LEN - 1);
  localparam logic [6:0] AC_L2_LAST = LINE2_BASE + 7'(LINE_LEN - 1);
  localparam logic [6:0] AC_1L_LAST = 7'(DDRAM_DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_FILL, ST_BUSY} state_t;

  function automatic logic [6:0] ac_next(input logic [6:0] ac, input logic inc,
                                         input logic two_line);
    if (two_line) begin
      if (inc) ac_next = (ac == AC_L1_LAST) ? LINE2_BASE :
                         (ac >= AC_L2_LAST) ? 7'h00 : ac + 7'd1;
      else     ac_next = (ac == LINE2_BASE) ? AC_L1_LAST :
                         (ac == 7'h00)      ? AC_L2_LAST : ac - 7'd1;
    end else begin
      if (inc) ac_next = (ac >= AC_1L_LAST) ? 7'h00 : ac + 7'd1;
      else     ac_next = (ac == 7'h00) ? AC_1L_LAST : ac - 7'd1;
    end
  endfunction

  function automatic logic ac_valid(input logic [6:0] ac, input logic two_line);
    if (two_line) ac_valid = (ac <= AC_L1_LAST) || (ac >= LINE2_BASE && ac <= AC_L2_LAST);
    else          ac_valid = (ac <= AC_1L_LAST);
  endfunction

  function automatic logic [6:0] phys_idx(input logic [6:0] ac);
    phys_idx = (ac < LINE2_BASE) ? ac : ac - LINE2_BASE + 7'(LINE_LEN);
  endfunction

endpackage

// File: rtl/hd44780_responder_if.sv
// HD44780 pin bus: the controller drives e/rs/db, the responder samples them.
interface hd44780_responder_if;
  logic       e;
  logic       rs;
  logic [3:0] db;

  modport master (output e, rs, db);
  modport slave  (input  e, rs, db);
endinterface

// File: rtl/hd44780_ddram.sv
// 80x8 display RAM: one synchronous write port, one registered read port (old data on collision).
module hd44780_ddram
  import hd44780_pkg::*;
(
  input  logic       clk,
  input  logic       i_we,
  input  logic [6:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [6:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [DDRAM_DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we && (i_waddr < 7'(DDRAM_DEPTH))) r_mem[i_waddr] <= i_wdata;
    r_rdata <= (i_raddr < 7'(DDRAM_DEPTH)) ? r_mem[i_raddr] : BLANK;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/hd44780_responder.sv
// Device end of the HD44780 write bus: synchronizes pins, assembles nibbles,
// executes instructions/data with a modelled busy time and owns the DDRAM.
module hd44780_responder
  import hd44780_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BUSY_CYCLES = 16,
  parameter int unsigned CLR_CYCLES  = 400
) (
  input  logic               clk,
  input  logic               rst,
  hd44780_responder_if.slave pins,
  output logic               busy,
  output logic               protocol_err,
  output logic               instr_valid,
  output logic [7:0]         instr_byte,
  output logic               instr_rs,
  output logic               iface_4bit,
  output logic               two_line,
  output logic               disp_on,
  output logic               cursor_on,
  output logic               blink_on,
  output logic               entry_inc,
  output logic               entry_shift,
  output logic [6:0]         ddram_addr,
  input  logic [6:0]         rd_addr,
  output logic [7:0]         rd_data
);

  localparam int unsigned CNT_W = $clog2(CLR_CYCLES > BUSY_CYCLES ? CLR_CYCLES : BUSY_CYCLES);
  localparam logic [CNT_W-1:0] CNT_BUSY = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_CLR  = CNT_W'(CLR_CYCLES - 1);

  logic [5:0] r_sync [SYNC_STAGES];
  logic       r_e_d;
  logic       w_e_s, w_rs_s, w_fall;
  logic [3:0] w_db_s;

  state_t           r_state;
  logic             r_busy, r_perr, r_valid, r_instr_rs;
  logic [7:0]       r_instr_byte, r_pend_byte;
  logic             r_pend_rs, r_phase_lo;
  logic [3:0]       r_hi;
  logic             r_iface_4bit, r_two_line, r_disp_on, r_cursor_on, r_blink_on;
  logic             r_entry_inc, r_entry_shift;
  logic [6:0]       r_ac, r_fill;
  logic [CNT_W-1:0] r_cnt;

  logic       w_we;
  logic [6:0] w_waddr;
  logic [7:0] w_wdata;

  // rs/db ride the same synchronizer chain as e so they stay aligned with the edge.
  assign {w_e_s, w_rs_s, w_db_s} = r_sync[SYNC_STAGES-1];
  assign w_fall = r_e_d & ~w_e_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_e_d <= 1'b0;
    end else begin
      r_sync[0] <= {pins.e, pins.rs, pins.db};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_e_d <= w_e_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_perr        <= 1'b0;
      r_valid       <= 1'b0;
      r_instr_byte  <= '0;
      r_instr_rs    <= 1'b0;
      r_pend_byte   <= '0;
      r_pend_rs     <= 1'b0;
      r_phase_lo    <= 1'b0;
      r_hi          <= '0;
      r_iface_4bit  <= 1'b0;
      r_two_line    <= 1'b0;
      r_disp_on     <= 1'b0;
      r_cursor_on   <= 1'b0;
      r_blink_on    <= 1'b0;
      r_entry_inc   <= 1'b1;
      r_entry_shift <= 1'b0;
      r_ac          <= '0;
      r_fill        <= '0;
      r_cnt         <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_fall && r_state != ST_IDLE) r_perr <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_fall) begin
          if (r_iface_4bit && !r_phase_lo) begin
            r_hi       <= w_db_s;
            r_phase_lo <= 1'b1;
          end else begin
            r_pend_byte <= r_iface_4bit ? {r_hi, w_db_s} : {w_db_s, 4'h0};
            r_pend_rs   <= w_rs_s;
            r_phase_lo  <= 1'b0;
            r_state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_valid      <= 1'b1;
          r_instr_byte <= r_pend_byte;
          r_instr_rs   <= r_pend_rs;
          r_busy       <= 1'b1;
          r_cnt        <= CNT_BUSY;
          r_state      <= ST_BUSY;
          if (r_pend_rs) begin
            r_ac <= ac_next(r_ac, r_entry_inc, r_two_line);
          end else if (|(r_pend_byte & SDL)) begin
            if (ac_valid(r_pend_byte[6:0], r_two_line)) r_ac <= r_pend_byte[6:0];
            else begin
              r_ac   <= '0;
              r_perr <= 1'b1;
            end
          end else if (|(r_pend_byte & SCGA)) begin
          end else if (|(r_pend_byte & FS)) begin
            r_iface_4bit <= ~r_pend_byte[FS_DL];
            r_two_line   <= r_pend_byte[FS_N];
            r_phase_lo   <= 1'b0;
          end else if (|(r_pend_byte & CD)) begin
            if (!r_pend_byte[CD_SC]) r_ac <= ac_next(r_ac, r_pend_byte[CD_RL], r_two_line);
          end else if (|(r_pend_byte & DC)) begin
            r_disp_on   <= r_pend_byte[DC_D];
            r_cursor_on <= r_pend_byte[DC_C];
            r_blink_on  <= r_pend_byte[DC_B];
          end else if (|(r_pend_byte & EM)) begin
            r_entry_inc   <= r_pend_byte[EM_ID];
            r_entry_shift <= r_pend_byte[EM_S];
          end else if (|(r_pend_byte & HOME)) begin
            r_ac <= '0;
          end else if (|(r_pend_byte & CLR)) begin
            r_cnt   <= CNT_CLR;
            r_fill  <= '0;
            r_state <= ST_FILL;
          end
        end
        // The busy countdown keeps running while the fill walks the RAM.
        ST_FILL: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
          if (r_fill == 7'(DDRAM_DEPTH - 1)) begin
            r_ac        <= '0;
            r_entry_inc <= 1'b1;
            if (r_cnt == '0) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_BUSY;
            end
          end else begin
            r_fill <= r_fill + 7'd1;
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!rst) begin
      if (r_state == ST_EXEC && r_pend_rs) begin
        w_we    = 1'b1;
        w_waddr = phys_idx(r_ac);
        w_wdata = r_pend_byte;
      end else if (r_state == ST_FILL) begin
        w_we    = 1'b1;
        w_waddr = r_fill;
        w_wdata = BLANK;
      end
    end
  end

  hd44780_ddram u_ddram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (phys_idx(rd_addr)),
    .o_rdata (rd_data)
  );

  assign busy         = r_busy;
  assign protocol_err = r_perr;
  assign instr_valid  = r_valid;
  assign instr_byte   = r_instr_byte;
  assign instr_rs     = r_instr_rs;
  assign iface_4bit   = r_iface_4bit;
  assign two_line     = r_two_line;
  assign disp_on      = r_disp_on;
  assign cursor_on    = r_cursor_on;
  assign blink_on     = r_blink_on;
  assign entry_inc    = r_entry_inc;
  assign entry_shift  = r_entry_shift;
  assign ddram_addr   = r_ac;

endmodule

// File: tb/tb_hd44780_responder.sv
// Scoreboard bench for hd44780_responder: directed bus sequences push expected executions,
// a monitor checks every instr_valid pulse; state and DDRAM reads are checked directly.
module tb_hd44780_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy, protocol_err, instr_valid, instr_rs;
  logic [7:0] instr_byte, rd_data;
  logic       iface_4bit, two_line, disp_on, cursor_on, blink_on, entry_inc, entry_shift;
  logic [6:0] ddram_addr, rd_addr;

  always #5 clk = ~clk;

  hd44780_responder_if pins ();

  hd44780_responder #(
    .SYNC_STAGES (2),
    .BUSY_CYCLES (16),
    .CLR_CYCLES  (400)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pins         (pins),
    .busy         (busy),
    .protocol_err (protocol_err),
    .instr_valid  (instr_valid),
    .instr_byte   (instr_byte),
    .instr_rs     (instr_rs),
    .iface_4bit   (iface_4bit),
    .two_line     (two_line),
    .disp_on      (disp_on),
    .cursor_on    (cursor_on),
    .blink_on     (blink_on),
    .entry_inc    (entry_inc),
    .entry_shift  (entry_shift),
    .ddram_addr   (ddram_addr),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       rs;
    logic [6:0] ac;
    logic       chk_ac;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_run = 0;
  int   busy_last = 0;
  bit   four = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nibble(input logic rs_v, input logic [3:0] d);
    @(negedge clk);
    pins.rs = rs_v;
    pins.db = d;
    pins.e  = 1'b1;
    repeat (2) @(negedge clk);
    pins.e = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s: busy still high after %0d cycles, expected low", name, n);
    end
  endtask

  task automatic send(input logic rs_v, input logic [7:0] b, input logic [6:0] ac,
                      input logic chk_ac);
    wait_idle("wait_before_send");
    q.push_back('{b: b, rs: rs_v, ac: ac, chk_ac: chk_ac});
    if (four) begin
      nibble(rs_v, b[7:4]);
      nibble(rs_v, b[3:0]);
    end else begin
      nibble(rs_v, b[7:4]);
    end
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  // Monitor: every executed byte must match the next expected entry.
  always @(negedge clk) begin
    exp_t x;
    if (!rst && instr_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_exec: got rs=%0d byte=0x%0h, expected no execution",
                 instr_rs, instr_byte);
      end else begin
        x = q.pop_front();
        checks++;
        if ({instr_rs, instr_byte} !== {x.rs, x.b}) begin
          errors++;
          $display("FAIL exec_byte: got rs=%0d byte=0x%0h, expected rs=%0d byte=0x%0h",
                   instr_rs, instr_byte, x.rs, x.b);
        end
        if (x.chk_ac) begin
          checks++;
          if (ddram_addr !== x.ac) begin
            errors++;
            $display("FAIL exec_ac: byte 0x%0h got AC 0x%0h, expected 0x%0h",
                     x.b, ddram_addr, x.ac);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (busy) busy_run++;
    else begin
      if (busy_run != 0) busy_last = busy_run;
      busy_run = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int bad;
    int n;
    pins.e  = 1'b0;
    pins.rs = 1'b0;
    pins.db = 4'h0;
    rd_addr = '0;
    rst     = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_perr", 32'(protocol_err), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_flags", 32'({iface_4bit, two_line, disp_on, cursor_on, blink_on, entry_inc, entry_shift}),
        32'b0000010);
    chk("rst_ac", 32'(ddram_addr), 32'h00);
    chk("rst_instr_byte", 32'(instr_byte), 32'h00);

    // Power-up order: one 8-bit function set, then 4-bit pairs.
    four = 1'b0;
    send(1'b0, 8'h20, 7'h00, 1'b1);
    four = 1'b1;
    send(1'b0, 8'h28, 7'h00, 1'b1);
    send(1'b0, 8'h0C, 7'h00, 1'b1);
    send(1'b0, 8'h06, 7'h00, 1'b1);
    wait_idle("init_idle");
    chk("init_flags", 32'({iface_4bit, two_line, disp_on, cursor_on, entry_inc}), 32'b11101);

    send(1'b0, 8'hC0, 7'h40, 1'b1);
    send(1'b1, 8'h41, 7'h41, 1'b1);
    send(1'b1, 8'h42, 7'h42, 1'b1);
    wait_idle("data_idle");
    repeat (2) @(negedge clk);
    chk("busy_len_data", 32'(busy_last), 32'd16);
    chk("data_ac", 32'(ddram_addr), 32'h42);
    rd(7'h40, d); chk("rd_40", 32'(d), 32'h41);
    rd(7'h41, d); chk("rd_41", 32'(d), 32'h42);

    send(1'b0, 8'hA7, 7'h27, 1'b1);
    send(1'b1, 8'h58, 7'h40, 1'b1);
    send(1'b0, 8'hE7, 7'h67, 1'b1);
    send(1'b1, 8'h59, 7'h00, 1'b1);
    send(1'b0, 8'h04, 7'h00, 1'b1);
    send(1'b1, 8'h5A, 7'h67, 1'b1);
    wait_idle("wrap_idle");
    chk("wrap_dec_ac", 32'(ddram_addr), 32'h67);
    rd(7'h27, d); chk("rd_27", 32'(d), 32'h58);
    rd(7'h00, d); chk("rd_00", 32'(d), 32'h5A);

    send(1'b1, 8'h33, 7'h66, 1'b1);
    chk("perr_clean", 32'(protocol_err), 32'd0);
    @(negedge clk);
    pins.rs = 1'b1;
    pins.db = 4'hF;
    pins.e  = 1'b1;
    repeat (2) @(negedge clk);
    pins.e = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_at_stray_edge", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    wait_idle("stray_idle");
    chk("stray_perr", 32'(protocol_err), 32'd1);
    chk("stray_ac", 32'(ddram_addr), 32'h66);
    send(1'b1, 8'h34, 7'h65, 1'b1);
    wait_idle("after_stray_idle");
    rd(7'h66, d); chk("rd_66", 32'(d), 32'h34);
    rd(7'h67, d); chk("rd_67", 32'(d), 32'h33);

    send(1'b0, 8'h01, 7'h00, 1'b0);
    wait_idle("clear_idle");
    repeat (2) @(negedge clk);
    chk("busy_len_clear", 32'(busy_last), 32'd400);
    chk("clear_ac", 32'(ddram_addr), 32'h00);
    chk("clear_entry_inc", 32'(entry_inc), 32'd1);
    bad = 0;
    for (int a = 0; a < 128; a++) begin
      if (a < 8'h28 || (a >= 8'h40 && a < 8'h68)) begin
        rd(7'(a), d);
        if (d !== 8'h20) bad++;
      end
    end
    chk("clear_fill_bad_count", 32'(bad), 32'd0);

    send(1'b0, 8'h01, 7'h00, 1'b0);
    n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (48) @(negedge clk);
    chk("busy_mid_clear", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_clear_busy", 32'(busy), 32'd0);
    chk("rst_mid_clear_4bit", 32'(iface_4bit), 32'd0);
    chk("rst_mid_clear_perr", 32'(protocol_err), 32'd0);
    four = 1'b0;
    send(1'b1, 8'h40, 7'h01, 1'b1);
    wait_idle("post_rst_idle");
    rd(7'h00, d); chk("rd_post_rst_00", 32'(d), 32'h40);

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
